// File: rtl/debounce_pkg.sv
// Shared debouncer definitions: FSM state encoding and the smallest legal qualification length.
// Pure declarations; no logic, no latency.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } state_t;

    localparam int unsigned MIN_STABLE_CYCLES = 2;

    // Counter must hold STABLE_CYCLES-1 with one bit of headroom so it can never wrap.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; 2-cycle latency, no backpressure.
// Both stages clear on synchronous active-low reset.
module sync_2ff (
    input  logic Clk,
    input  logic Resetn,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: Q follows D_raw once it has held for STABLE_CYCLES synchronized samples.
// Fixed latency STABLE_CYCLES+2 edges from first sample to new Q; no backpressure, Rise/Fall are single-cycle pulses.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic D_raw,
    output logic Q,
    output logic Rise,
    output logic Fall,
    output logic Busy
);

    localparam int unsigned CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic s;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          q_q, q_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q, busy_d;

    sync_2ff u_sync (
        .Clk    (Clk),
        .Resetn (Resetn),
        .d      (D_raw),
        .q      (s)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: if (s) begin
                state_d = PEND_HI;
                count_d = CNT_ONE;
            end
            STABLE_HI: if (!s) begin
                state_d = PEND_LO;
                count_d = CNT_ONE;
            end
            PEND_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    count_d = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    count_d = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                count_d = '0;
            end
        endcase
        // Busy is derived from the next state so it lands in the same cycle as the state it describes.
        busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= STABLE_LO;
            count_q <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign Q    = q_q;
    assign Rise = rise_q;
    assign Fall = fall_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (STABLE_CYCLES=4): directed scenarios plus random bouncing input,
// checked against a run-length reference model of the debounce rule.
module tb_switch_debouncer;

    localparam int N = 4;

    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    logic D_raw = 1'b0;
    logic Q, Rise, Fall, Busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: raw input travels two sample stages, then Q flips once
    // N consecutive samples disagree with it.
    logic m_d1 = 1'b0, m_d2 = 1'b0;
    logic m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
    int   m_run = 0;

    int rise_seen = 0;
    int fall_seen = 0;

    switch_debouncer #(.STABLE_CYCLES(N)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .D_raw  (D_raw),
        .Q      (Q),
        .Rise   (Rise),
        .Fall   (Fall),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic model_edge(input logic raw, input logic rstn);
        logic s;
        if (!rstn) begin
            m_d1 = 0; m_d2 = 0; m_q = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0;
        end else begin
            s = m_d2;
            m_d2 = m_d1;
            m_d1 = raw;
            m_rise = 0;
            m_fall = 0;
            if (s != m_q) begin
                m_run++;
                if (m_run == N) begin
                    m_q = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_busy = (m_run > 0);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: drive, advance the model, sample outputs 1 time unit after the edge.
    task automatic step(input logic raw, input logic rstn);
        D_raw = raw;
        Resetn = rstn;
        @(posedge Clk);
        model_edge(raw, rstn);
        #1;
        check_bit("Q", Q, m_q);
        check_bit("Rise", Rise, m_rise);
        check_bit("Fall", Fall, m_fall);
        check_bit("Busy", Busy, m_busy);
        check_bit("RiseFallExcl", Rise & Fall, 1'b0);
        if (Rise === 1'b1) rise_seen++;
        if (Fall === 1'b1) fall_seen++;
    endtask

    logic [8:0] bounce_pat;
    int hold;
    logic rnd_raw;

    initial begin
        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check_bit("reset_Q", Q, 1'b0);
        check_bit("reset_Busy", Busy, 1'b0);

        // Clean rise: Busy after edges 2-4, Q and Rise after edge 5.
        rise_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            if (i >= 2 && i <= 4) check_bit("rise_busy", Busy, 1'b1);
            if (i == 4) check_bit("rise_q_early", Q, 1'b0);
            if (i == 5) begin
                check_bit("rise_q", Q, 1'b1);
                check_bit("rise_pulse", Rise, 1'b1);
            end
        end
        check_int("rise_count", rise_seen, 1);

        // Clean fall.
        fall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            if (i == 5) check_bit("fall_q", Q, 1'b0);
        end
        check_int("fall_count", fall_seen, 1);

        // Glitch of 3 cycles.
        rise_seen = 0; fall_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        check_int("glitch_rise", rise_seen, 0);
        check_int("glitch_fall", fall_seen, 0);
        check_bit("glitch_busy", Busy, 1'b0);

        // Bounce 1,0,1,1,0,1,1,1,1 then held high.
        bounce_pat = 9'b111101101;
        rise_seen = 0; fall_seen = 0;
        for (int i = 0; i < 9; i++) step(bounce_pat[i], 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        check_bit("bounce_q", Q, 1'b1);
        check_int("bounce_rise", rise_seen, 1);
        check_int("bounce_fall", fall_seen, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

        // Reset while PEND_HI with count=2, D_raw held high throughout.
        rise_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_bit("midrst_q", Q, 1'b0);
        check_int("midrst_rise", rise_seen, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            if (i == 4) check_bit("midrst_q_early", Q, 1'b0);
            if (i == 5) check_bit("midrst_q_late", Q, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

        // Reset exactly on the acceptance edge.
        rise_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_bit("accrst_q", Q, 1'b0);
        check_bit("accrst_rise", Rise, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check_int("accrst_rise_count", rise_seen, 0);

        // Random bouncing with occasional resets.
        for (int blk = 0; blk < 300; blk++) begin
            rnd_raw = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) step(rnd_raw, ($urandom_range(0, 59) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive synchronized samples needed to accept a new level; legal range 2..65535.
REQ-002 Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  is the synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-004 D_raw  input  1  is the asynchronous, bouncing switch level (SW bit).
REQ-005 Q  output  1  is the debounced level, registered; it feeds the downstream master-slave flip-flop stage as its data or clock source.
REQ-006 Rise  output  1  is a one-cycle pulse, registered, asserted in the first cycle Q reads 1 after being 0.
REQ-007 Fall  output  1  is a one-cycle pulse, registered, asserted in the first cycle Q reads 0 after being 1.
REQ-008 Busy  output  1  is high while a candidate level change is being qualified (PEND states).

Function
REQ-009 D_raw SHALL pass through a two-stage synchronizer; S denotes the second-stage output, and no other logic SHALL read D_raw.
REQ-010 The FSM SHALL have four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-011 In STABLE_LO with S=1, the FSM SHALL go to PEND_HI and set count=1; in STABLE_HI with S=0, it SHALL go to PEND_LO and set count=1.
REQ-012 In a PEND state, if S still differs from Q and count<STABLE_CYCLES-1, count SHALL increment.
REQ-013 In a PEND state, if S still differs from Q and count=STABLE_CYCLES-1, Q SHALL take S, the FSM SHALL enter the matching STABLE state, count SHALL clear, and Rise or Fall SHALL assert in the next cycle together with the new Q.
REQ-014 In a PEND state, if S equals Q, the FSM SHALL return to the prior STABLE state with count cleared, and Q, Rise and Fall SHALL be unchanged.
REQ-015 Latency SHALL be fixed: with the first rising edge that samples a new, held D_raw counted as edge 0, Q SHALL change after edge STABLE_CYCLES+1.
REQ-016 Any S pulse of fewer than STABLE_CYCLES cycles SHALL produce no change on Q, Rise or Fall.
REQ-017 Rise and Fall SHALL never both be high, and each SHALL be high for exactly one cycle per Q transition.
REQ-018 The counter width SHALL be clog2(STABLE_CYCLES)+1 bits, and the counter SHALL never wrap.
REQ-019 Busy SHALL equal (state==PEND_HI || state==PEND_LO), registered with the state.

Reset
REQ-020 When Resetn=0 at an edge, the synchronizer stages, Q, Rise, Fall, Busy and count SHALL all be 0 and the state SHALL be STABLE_LO.
REQ-021 Reset SHALL take priority over every transition, including an acceptance edge under REQ-013; an aborted PEND SHALL produce no pulse.
REQ-022 If D_raw is held at 1 through the release of reset, Q SHALL rise with the full REQ-015 latency, counted from the first edge with Resetn=1.

Structure
REQ-023 The state encoding constants and the minimum STABLE_CYCLES value SHALL live in a shared package, debounce_pkg.
REQ-024 The synchronizer SHALL be the one sub-module, sync_2ff (ports Clk, Resetn, d, q); the FSM and counter SHALL stay in switch_debouncer.

Verification (STABLE_CYCLES=4)
REQ-025 Clean rise: D_raw goes 0->1 before edge 0 and is held -> Q=1 after edge 5, Rise=1 for exactly the cycle after edge 5, Busy=1 after edges 2-4.
REQ-026 Glitch: D_raw=1 for 3 cycles then back to 0 -> Q, Rise and Fall stay 0 throughout, and Busy returns to 0.
REQ-027 Bounce: D_raw pattern 1,0,1,1,0,1,1,1,1 (then held at 1) -> exactly one Rise, Q=1 after the fourth consecutive 1 in S, and no Fall.
REQ-028 Clean fall from Q=1: D_raw goes 1->0 and is held -> Q=0 after edge 5 and exactly one Fall pulse.
REQ-029 Reset mid-PEND_HI (count=2, Resetn=0 for 1 cycle, D_raw held at 1) -> Q=0 with no Rise during reset, then Q=1 after edge 5 counted from reset release.
REQ-030 Reset on the acceptance edge (Resetn=0 on edge 5 of the clean-rise scenario) -> Q stays 0 and no Rise pulse is produced.
